// File: rtl/top_pkg.sv
// Shared state encoding and command/config word layout for the DRAM transfer engine.
package top_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_CMD,
    S_CFG_RD,
    S_RD_CMD,
    S_RD_DAT,
    S_WR_CMD,
    S_WR_DAT,
    S_FNH
  } state_e;

  localparam int CMD_DIR      = 0;
  localparam int CMD_ADDR_LSB = 1;
  localparam int CMD_NUM_LSB  = 33;
  localparam int CMD_ADDR_W   = 32;
  localparam int CMD_NUM_W    = 16;
  localparam int CMD_W        = 49;

  localparam int CFG_SRC_LSB = 0;
  localparam int CFG_DST_LSB = 32;
  localparam int CFG_NUM_LSB = 64;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  function automatic logic [CMD_W-1:0] cmd_word(input logic dir,
                                                input logic [CMD_ADDR_W-1:0] addr,
                                                input logic [CMD_NUM_W-1:0] num);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_DIR] = dir;
    w[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    w[CMD_NUM_LSB +: CMD_NUM_W] = num;
    return w;
  endfunction

endpackage

// File: rtl/top_buf.sv
// Chunk buffer: one write port, one read port, pointers cleared at the start of each chunk.
module top_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q + AW'(we);
    rptr_d = rptr_q + AW'(re);
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];

endmodule

// File: rtl/top.sv
// Half-duplex DRAM port owner: fetches a config word, then copies N words src->dst in buffer-sized chunks.
// state | meaning: IDLE wait start edge | CFG_CMD/CFG_RD fetch config | RD_CMD/RD_DAT fill buffer
//                  WR_CMD/WR_DAT drain buffer | FNH raise done flag
module top
  import top_pkg::*;
#(
  parameter int                         CLOCK_PERIOD    = 10,
  parameter int                         PORT_WIDTH      = 128,
  parameter int                         ADDR_WIDTH      = 16,
  parameter int                         DRAM_ADDR_WIDTH = 32,
  parameter int                         BUF_DEPTH       = 16,
  parameter logic [DRAM_ADDR_WIDTH-1:0] CFG_ADDR        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I_StartPulse,
  input  logic                  I_BypAsysnFIFO,
  output logic                  O_DatOE,
  inout  wire  [PORT_WIDTH-1:0] IO_Dat,
  inout  wire                   IO_DatVld,
  inout  wire                   IO_DatLast,
  inout  wire                   OI_DatRdy,
  output logic                  O_NetFnh
);
  localparam int unused_clock_period = CLOCK_PERIOD;
  localparam logic [ADDR_WIDTH-1:0] DEPTH   = ADDR_WIDTH'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  state_e                     state_q, state_d;
  logic                       start_q, fnh_q, fnh_d;
  logic [DRAM_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, off_q, off_d;
  logic [ADDR_WIDTH-1:0]      num_q, num_d, chunk_q, chunk_d, cnt_q, cnt_d, chunk_nxt;
  logic                       oe, vld_o, last_o, rdy_o, xfer, rd_end, start_edge;
  logic [PORT_WIDTH-1:0]      dat_o, buf_rdata;
  logic                       buf_clr, buf_we, buf_re;
  logic                       unused_byp;

  assign unused_byp = I_BypAsysnFIFO;
  assign start_edge = I_StartPulse & ~start_q;
  assign chunk_nxt  = (num_q > DEPTH) ? DEPTH : num_q;

  assign oe     = !(state_q inside {S_CFG_RD, S_RD_DAT});
  assign rdy_o  = !oe && (cnt_q != '0);
  assign vld_o  = state_q inside {S_CFG_CMD, S_RD_CMD, S_WR_CMD, S_WR_DAT};
  assign last_o = (state_q inside {S_CFG_CMD, S_RD_CMD, S_WR_CMD}) ||
                  (state_q == S_WR_DAT && cnt_q == CNT_ONE);

  assign IO_Dat     = oe ? dat_o  : {PORT_WIDTH{1'bz}};
  assign IO_DatVld  = oe ? vld_o  : 1'bz;
  assign IO_DatLast = oe ? last_o : 1'bz;
  assign OI_DatRdy  = oe ? 1'bz   : rdy_o;
  assign O_DatOE    = oe;
  assign O_NetFnh   = fnh_q;

  // Handshake is qualified with our own half so the bus read-back never feeds itself.
  assign xfer   = oe ? (vld_o & OI_DatRdy) : (IO_DatVld & rdy_o);
  assign rd_end = xfer && (IO_DatLast || cnt_q == CNT_ONE);

  always_comb begin
    dat_o = '0;
    case (state_q)
      S_CFG_CMD: dat_o = PORT_WIDTH'(cmd_word(DIR_RD, CFG_ADDR, CMD_NUM_W'(1)));
      S_RD_CMD:  dat_o = PORT_WIDTH'(cmd_word(DIR_RD, src_q + off_q, chunk_nxt));
      S_WR_CMD:  dat_o = PORT_WIDTH'(cmd_word(DIR_WR, dst_q + off_q, chunk_q));
      S_WR_DAT:  dat_o = buf_rdata;
      default:   dat_o = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fnh_d   = fnh_q;
    src_d   = src_q;
    dst_d   = dst_q;
    off_d   = off_q;
    num_d   = num_q;
    chunk_d = chunk_q;
    cnt_d   = cnt_q;
    buf_clr = 1'b0;
    buf_we  = 1'b0;
    buf_re  = 1'b0;
    case (state_q)
      S_IDLE: if (start_edge) begin
        fnh_d   = 1'b0;
        state_d = S_CFG_CMD;
      end
      S_CFG_CMD: if (xfer) begin
        cnt_d   = CNT_ONE;
        state_d = S_CFG_RD;
      end
      S_CFG_RD: begin
        if (xfer) cnt_d = cnt_q - CNT_ONE;
        if (rd_end) begin
          src_d   = IO_Dat[CFG_SRC_LSB +: DRAM_ADDR_WIDTH];
          dst_d   = IO_Dat[CFG_DST_LSB +: DRAM_ADDR_WIDTH];
          num_d   = IO_Dat[CFG_NUM_LSB +: ADDR_WIDTH];
          off_d   = '0;
          state_d = (IO_Dat[CFG_NUM_LSB +: ADDR_WIDTH] == '0) ? S_FNH : S_RD_CMD;
        end
      end
      S_RD_CMD: if (xfer) begin
        cnt_d   = chunk_nxt;
        chunk_d = chunk_nxt;
        buf_clr = 1'b1;
        state_d = S_RD_DAT;
      end
      S_RD_DAT: begin
        if (xfer) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q - CNT_ONE;
        end
        if (rd_end) state_d = S_WR_CMD;
      end
      S_WR_CMD: if (xfer) begin
        cnt_d   = chunk_q;
        state_d = S_WR_DAT;
      end
      S_WR_DAT: if (xfer) begin
        buf_re = 1'b1;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          num_d   = num_q - chunk_q;
          off_d   = off_q + DRAM_ADDR_WIDTH'(chunk_q);
          state_d = (num_q == chunk_q) ? S_FNH : S_RD_CMD;
        end
      end
      S_FNH: begin
        fnh_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      fnh_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      off_q   <= '0;
      num_q   <= '0;
      chunk_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= I_StartPulse;
      fnh_q   <= fnh_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      off_q   <= off_d;
      num_q   <= num_d;
      chunk_q <= chunk_d;
      cnt_q   <= cnt_d;
    end
  end

  top_buf #(.DEPTH(BUF_DEPTH), .WIDTH(PORT_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buf_clr),
    .we    (buf_we),
    .wdata (IO_Dat),
    .re    (buf_re),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_top.sv
// Bench for top: behavioural DRAM on the half-duplex port, command scoreboard and copy checks.
module tb_top;
  localparam int PW = 128;

  logic clk = 1'b0;
  logic rst_n, start, byp;
  logic oe, fnh;
  wire [PW-1:0] io_dat;
  wire io_vld, io_last, oi_rdy;

  logic [PW-1:0] tb_dat;
  logic tb_vld, tb_last, tb_rdy;

  assign io_dat  = oe ? {PW{1'bz}} : tb_dat;
  assign io_vld  = oe ? 1'bz : tb_vld;
  assign io_last = oe ? 1'bz : tb_last;
  assign oi_rdy  = oe ? tb_rdy : 1'bz;

  always #5 clk = ~clk;

  top #(.CLOCK_PERIOD(10), .PORT_WIDTH(PW), .ADDR_WIDTH(16), .DRAM_ADDR_WIDTH(32),
        .BUF_DEPTH(16), .CFG_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .I_StartPulse(start), .I_BypAsysnFIFO(byp),
    .O_DatOE(oe), .IO_Dat(io_dat), .IO_DatVld(io_vld), .IO_DatLast(io_last),
    .OI_DatRdy(oi_rdy), .O_NetFnh(fnh)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] src_data[$];
  logic [127:0] dram [bit [31:0]];
  logic [31:0]  rd_base, wr_base;
  int rd_cnt, rd_idx, wr_left, wr_idx, wr_seen;
  bit xfer_rd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_cmd(input bit dir, input logic [31:0] a, input logic [15:0] n);
    return {79'd0, n, a, dir};
  endfunction

  function automatic logic [127:0] rd_word(input logic [31:0] a);
    return dram.exists(a) ? dram[a] : '0;
  endfunction

  task automatic take_word();
    logic [127:0] e;
    if (wr_left == 0) begin
      e = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
      chk("cmd", io_dat, e);
      chk("cmd_last", io_last, 1'b1);
      if (io_dat[0]) begin
        wr_base = io_dat[32:1];
        wr_left = int'(io_dat[48:33]);
        wr_idx  = 0;
      end else begin
        rd_base = io_dat[32:1];
        rd_cnt  = int'(io_dat[48:33]);
        rd_idx  = 0;
      end
    end else begin
      dram[wr_base + 32'(wr_idx)] = io_dat;
      chk("wr_last", io_last, (wr_left == 1));
      wr_idx++;
      wr_left--;
      wr_seen++;
    end
  endtask

  // DRAM side: random ready when the DUT drives, random valid bubbles when it listens.
  initial begin
    tb_vld = 0; tb_last = 0; tb_rdy = 0; tb_dat = '0;
    rd_cnt = 0; rd_idx = 0; wr_left = 0; wr_idx = 0; wr_seen = 0; xfer_rd = 0;
    rd_base = '0; wr_base = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tb_vld = 0; tb_last = 0; tb_rdy = 0; xfer_rd = 0;
        rd_cnt = 0; rd_idx = 0; wr_left = 0;
      end else if (oe) begin
        tb_vld = 0; tb_last = 0; xfer_rd = 0;
        tb_rdy = ($urandom_range(0, 3) != 0);
        if (io_vld === 1'b1 && tb_rdy) take_word();
      end else begin
        tb_rdy = 0;
        if (xfer_rd) begin tb_vld = 0; xfer_rd = 0; end
        if (rd_idx < rd_cnt) begin
          if (!tb_vld) tb_vld = ($urandom_range(0, 3) != 0);
          tb_dat  = rd_word(rd_base + 32'(rd_idx));
          tb_last = (rd_idx == rd_cnt - 1);
          if (tb_vld && oi_rdy === 1'b1) begin rd_idx++; xfer_rd = 1; end
        end else begin
          tb_vld = 0; tb_last = 0;
        end
      end
    end
  end

  task automatic setup_job(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [127:0] w;
    int off, rem, c;
    src_data.delete();
    for (int i = 0; i < n; i++) dram.delete(dst + 32'(i));
    dram[32'h0] = {48'd0, 16'(n), dst, src};
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      dram[src + 32'(i)] = w;
      src_data.push_back(w);
    end
    exp_q.push_back(mk_cmd(1'b0, 32'h0, 16'd1));
    off = 0; rem = n;
    while (rem > 0) begin
      c = (rem > 16) ? 16 : rem;
      exp_q.push_back(mk_cmd(1'b0, src + 32'(off), 16'(c)));
      exp_q.push_back(mk_cmd(1'b1, dst + 32'(off), 16'(c)));
      off += c; rem -= c;
    end
  endtask

  task automatic wait_fnh();
    for (int i = 0; i < 3000 && fnh !== 1'b1; i++) @(negedge clk);
    chk("fnh", fnh, 1'b1);
  endtask

  task automatic run_job(input int hold);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    chk("start_vld", io_vld, 1'b1);
    chk("start_fnh", fnh, 1'b0);
    repeat (hold - 1) @(negedge clk);
    start = 0;
    wait_fnh();
    repeat (20) @(negedge clk);
    chk("cmd_left", 128'(exp_q.size()), '0);
    chk("fnh_hold", fnh, 1'b1);
  endtask

  task automatic check_dst(input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++) chk("dst", rd_word(dst + 32'(i)), src_data[i]);
  endtask

  initial begin
    int w0;
    rst_n = 0; start = 0; byp = 0;
    repeat (3) @(negedge clk);
    chk("rst_oe", oe, 1'b1);
    chk("rst_vld", io_vld, 1'b0);
    chk("rst_last", io_last, 1'b0);
    chk("rst_dat", io_dat, '0);
    chk("rst_fnh", fnh, 1'b0);
    rst_n = 1;

    setup_job(32'h100, 32'h200, 4);
    run_job(1);
    check_dst(32'h200, 4);

    w0 = wr_seen;
    setup_job(32'h500, 32'h600, 0);
    run_job(1);
    chk("empty_nowr", 128'(wr_seen - w0), '0);

    setup_job(32'h1000, 32'hFFFF_FFF0, 40);
    run_job(1);
    check_dst(32'hFFFF_FFF0, 40);

    setup_job(32'h100, 32'h200, 4);
    run_job(10);
    check_dst(32'h200, 4);
    setup_job(32'h100, 32'h200, 4);
    run_job(1);
    check_dst(32'h200, 4);

    setup_job(32'h1000, 32'h2000, 40);
    w0 = wr_seen;
    @(negedge clk);
    start = 1;
    for (int i = 0; i < 2000 && wr_seen < w0 + 3; i++) @(negedge clk);
    chk("mid_wr_reached", (wr_seen >= w0 + 3), 1'b1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_oe", oe, 1'b1);
    chk("mid_rst_vld", io_vld, 1'b0);
    chk("mid_rst_last", io_last, 1'b0);
    chk("mid_rst_dat", io_dat, '0);
    chk("mid_rst_fnh", fnh, 1'b0);
    start = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    setup_job(32'h1000, 32'h2000, 40);
    run_job(1);
    check_dst(32'h2000, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
